// File: rtl/fan_ctrl_pkg.sv
// Shared constants and FSM state encoding for the fan PWM controller.
package fan_ctrl_pkg;

  localparam int unsigned ADC_BITWIDTH_DFLT = 4;
  localparam int unsigned PWM_STEPS = (32'd1 << ADC_BITWIDTH_DFLT) - 32'd1;

  typedef enum logic [1:0] {
    StOff  = 2'd0,
    StKick = 2'd1,
    StRun  = 2'd2
  } fan_state_e;

  function automatic int unsigned pwm_steps(input int unsigned bw);
    return (32'd1 << bw) - 32'd1;
  endfunction

endpackage

// File: rtl/fan_clk_div.sv
// PWM step prescaler: counts 0..CLK_DIV-1 and flags the last count as a step tick.
module fan_clk_div #(
  parameter int unsigned CLK_DIV = 3
) (
  input  logic clk,
  input  logic rst,
  output logic tick_o
);

  logic [7:0] r_cnt;
  logic       w_wrap;

  assign w_wrap = (r_cnt == 8'(CLK_DIV - 32'd1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_wrap) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  assign tick_o = w_wrap;

endmodule

// File: rtl/fan_pwm_gen.sv
// Fan PWM generator with boundary-aligned duty updates.
// Optional kick-start (full duty for KICK_PERIODS periods) enabled by FAN_PWM_KICKSTART_EN.
module fan_pwm_gen
  import fan_ctrl_pkg::*;
#(
  parameter int unsigned ADC_BITWIDTH = ADC_BITWIDTH_DFLT,
  parameter int unsigned CLK_DIV      = 3,
  parameter int unsigned KICK_PERIODS = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADC_BITWIDTH:0]   pid_val,
  input  logic                    pid_valid,
  output logic                    pwm_o,
  output logic [ADC_BITWIDTH-1:0] duty_o,
  output logic                    period_start_o,
  output logic                    kick_o
);

  localparam logic [ADC_BITWIDTH-1:0] STEP_LAST =
      ADC_BITWIDTH'(pwm_steps(ADC_BITWIDTH) - 32'd1);
  localparam logic [ADC_BITWIDTH-1:0] DUTY_FULL = ADC_BITWIDTH'(pwm_steps(ADC_BITWIDTH));

  logic                    w_tick;
  logic                    w_boundary;
  logic [ADC_BITWIDTH-1:0] w_clamped;
  logic [ADC_BITWIDTH-1:0] r_step, w_step_d;
  logic [ADC_BITWIDTH-1:0] r_pending;
  logic [ADC_BITWIDTH-1:0] r_duty, w_duty_d;
  logic [ADC_BITWIDTH-1:0] r_duty_o, w_applied_d;
  fan_state_e              r_state, w_state_d;
  logic                    r_pwm;
  logic                    r_period_start;

  fan_clk_div #(
    .CLK_DIV(CLK_DIV)
  ) u_clk_div (
    .clk   (clk),
    .rst   (rst),
    .tick_o(w_tick)
  );

  assign w_clamped  = pid_val[ADC_BITWIDTH] ? '0 : pid_val[ADC_BITWIDTH-1:0];
  assign w_boundary = w_tick && (r_step == STEP_LAST);

  always_comb begin
    w_step_d = r_step;
    if (w_tick) begin
      w_step_d = (r_step == STEP_LAST) ? '0 : r_step + 1'b1;
    end
    w_duty_d = w_boundary ? r_pending : r_duty;
  end

`ifdef FAN_PWM_KICKSTART_EN
  localparam int unsigned KICK_W = (KICK_PERIODS < 1) ? 1 : $clog2(KICK_PERIODS + 1);

  logic [KICK_W-1:0] r_kick, w_kick_d;

  always_comb begin
    w_state_d = r_state;
    w_kick_d  = r_kick;
    if (w_boundary) begin
      case (r_state)
        StOff: begin
          if (r_pending != '0) begin
            w_state_d = StKick;
            w_kick_d  = '0;
          end
        end
        StKick: begin
          if (r_pending == '0) begin
            w_state_d = StOff;
          end else begin
            // Saturating count of boundaries elapsed while kicking.
            if (r_kick != {KICK_W{1'b1}}) w_kick_d = r_kick + 1'b1;
            if (32'(w_kick_d) >= KICK_PERIODS) w_state_d = StRun;
          end
        end
        StRun: begin
          if (r_pending == '0) w_state_d = StOff;
        end
        default: w_state_d = StOff;
      endcase
    end
    w_applied_d = (w_state_d == StKick) ? DUTY_FULL : w_duty_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_kick <= '0;
    end else begin
      r_kick <= w_kick_d;
    end
  end

  assign kick_o = (r_state == StKick);
`else
  always_comb begin
    w_state_d = r_state;
    if (w_boundary) begin
      w_state_d = (r_pending != '0) ? StRun : StOff;
    end
    w_applied_d = w_duty_d;
  end

  assign kick_o = 1'b0;
`endif

  // PWM compares the next step against the next applied duty so the output flop
  // tracks (step < duty) cycle-exactly without combinational glitches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_step         <= '0;
      r_pending      <= '0;
      r_duty         <= '0;
      r_duty_o       <= '0;
      r_state        <= StOff;
      r_pwm          <= 1'b0;
      r_period_start <= 1'b0;
    end else begin
      r_step         <= w_step_d;
      if (pid_valid) r_pending <= w_clamped;
      r_duty         <= w_duty_d;
      r_duty_o       <= w_applied_d;
      r_state        <= w_state_d;
      r_pwm          <= (w_step_d < w_applied_d);
      r_period_start <= w_boundary;
    end
  end

  assign pwm_o          = r_pwm;
  assign duty_o         = r_duty_o;
  assign period_start_o = r_period_start;

endmodule

// File: tb/tb_fan_pwm_gen.sv
// Self-checking bench for fan_pwm_gen: period-level reference model plus directed checks.
module tb_fan_pwm_gen;

  localparam int ADC     = 4;
  localparam int CLK_DIV = 3;
  localparam int KICKS   = 8;
  localparam int STEPS   = 15;
  localparam int PERIOD  = CLK_DIV * STEPS;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [ADC:0] pid_val = '0;
  logic         pid_valid = 1'b0;
  logic         pwm_o;
  logic [ADC-1:0] duty_o;
  logic         period_start_o;
  logic         kick_o;

  int n_vec = 0;
  int n_err = 0;

  fan_pwm_gen #(
    .ADC_BITWIDTH(ADC),
    .CLK_DIV     (CLK_DIV),
    .KICK_PERIODS(KICKS)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pid_val       (pid_val),
    .pid_valid     (pid_valid),
    .pwm_o         (pwm_o),
    .duty_o        (duty_o),
    .period_start_o(period_start_o),
    .kick_o        (kick_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: time since reset release decides step and boundaries; each period
  // gets one duty chosen from the pending value and the off/kick/run mode.
  int   cyc = 0;
  int   m_pending = 0;
  int   m_applied = 0;
  int   m_mode = 0;  // 0 off, 1 kick, 2 run
  int   m_kick_left = 0;
  bit   m_pstart = 0;
  int   ld;
  logic s_rst, s_v;
  logic [ADC:0] s_val;

  always @(posedge clk) begin
    s_rst = rst;
    s_v   = pid_valid;
    s_val = pid_val;
    #1;
    if (s_rst || rst) begin
      cyc = 0; m_pending = 0; m_applied = 0; m_mode = 0; m_kick_left = 0; m_pstart = 0;
    end else begin
      cyc++;
      m_pstart = (cyc % PERIOD == 0);
      if (m_pstart) begin
        ld = m_pending;
`ifdef FAN_PWM_KICKSTART_EN
        if (ld == 0) m_mode = 0;
        else if (m_mode == 0) begin
          m_mode = 1;
          m_kick_left = KICKS - 1;
        end else if (m_mode == 1) begin
          if (m_kick_left == 0) m_mode = 2;
          else m_kick_left--;
        end
        m_applied = (m_mode == 1) ? STEPS : ld;
`else
        m_mode = (ld == 0) ? 0 : 2;
        m_applied = ld;
`endif
      end
      if (s_v) m_pending = s_val[ADC] ? 0 : int'(s_val[ADC-1:0]);
    end
    chk("pwm_o", pwm_o, ((cyc / CLK_DIV) % STEPS) < m_applied);
    chk("duty_o", duty_o, m_applied);
    chk("period_start_o", period_start_o, m_pstart);
    chk("kick_o", kick_o, m_mode == 1);
  end

  task automatic strobe(input logic [ADC:0] v);
    @(negedge clk);
    pid_val = v;
    pid_valid = 1'b1;
    @(negedge clk);
    pid_valid = 1'b0;
  endtask

  task automatic wait_pstart(input string nm);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!period_start_o && k < 200);
    if (!period_start_o) chk({nm, "_timeout"}, 0, 1);
  endtask

  // Starts on the first cycle of a period; returns on the first cycle of the next one.
  task automatic measure(output int hi, output int len);
    hi = 0;
    len = 0;
    do begin
      hi += int'(pwm_o);
      len++;
      @(negedge clk);
    end while (!period_start_o && len < 200);
  endtask

  int hi, len, pulses, first, last, gap_bad, k;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_pwm", pwm_o, 0);
    chk("rst_duty", duty_o, 0);
    chk("rst_pstart", period_start_o, 0);
    chk("rst_kick", kick_o, 0);
    rst = 1'b0;

    // Idle after reset: boundaries every 45 cycles, first on the 45th edge.
    pulses = 0; first = 0; last = 0; gap_bad = 0; hi = 0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      hi += int'(pwm_o);
      if (period_start_o) begin
        if (pulses == 0) first = i;
        else if (i - last != 45) gap_bad++;
        last = i;
        pulses++;
      end
    end
    chk("idle_pulses", pulses, 4);
    chk("idle_first_pulse", first, 45);
    chk("idle_gap_errs", gap_bad, 0);
    chk("idle_pwm_high", hi, 0);

    strobe(5'd5);
    wait_pstart("duty5");
    chk("duty5_duty", duty_o, 5);
    measure(hi, len);
    chk("duty5_high", hi, 15);
    chk("duty5_len", len, 45);

    strobe(5'b11101);  // -3
    wait_pstart("neg");
    chk("neg_duty", duty_o, 0);
    measure(hi, len);
    chk("neg_high", hi, 0);

    strobe(5'd15);
    wait_pstart("full");
    measure(hi, len);
    chk("full_high", hi, 45);
    chk("full_len", len, 45);

    strobe(5'd2);
    wait_pstart("run2");
    chk("run2_duty", duty_o, 2);
    // Strobe sampled on the boundary edge itself.
    repeat (44) @(negedge clk);
    pid_val = 5'd9;
    pid_valid = 1'b1;
    @(negedge clk);
    pid_valid = 1'b0;
    chk("bnd_pstart", period_start_o, 1);
    chk("bnd_duty_hold", duty_o, 2);
    measure(hi, len);
    chk("bnd_hold_high", hi, 6);
    chk("bnd_new_duty", duty_o, 9);
    measure(hi, len);
    chk("bnd_new_high", hi, 27);

    // Asynchronous reset in the high phase.
    repeat (5) @(negedge clk);
    chk("pre_rst_pwm", pwm_o, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_pwm", pwm_o, 0);
    chk("async_rst_duty", duty_o, 0);
    @(negedge clk);
    rst = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!period_start_o && k < 200);
    chk("rst_restart_cycles", k, 45);
    chk("rst_restart_duty", duty_o, 0);

`ifdef FAN_PWM_KICKSTART_EN
    strobe(5'd4);
    wait_pstart("kick");
    k = 0;
    hi = 0;
    while (kick_o && k < 1000) begin
      hi += int'(pwm_o);
      k++;
      @(negedge clk);
    end
    chk("kick_cycles", k, 360);
    chk("kick_pwm_high", hi, 360);
    chk("kick_run_duty", duty_o, 4);
    measure(hi, len);
    chk("kick_run_high", hi, 12);

    strobe(5'd0);
    wait_pstart("kick_off");
    strobe(5'd7);
    wait_pstart("kick2");
    chk("kick2_active", kick_o, 1);
    chk("kick2_duty", duty_o, 15);
    strobe(5'd0);
    wait_pstart("kick_abort");
    chk("kick_abort_kick", kick_o, 0);
    chk("kick_abort_duty", duty_o, 0);
`else
    strobe(5'd7);
    wait_pstart("run7");
    chk("run7_kick", kick_o, 0);
    measure(hi, len);
    chk("run7_high", hi, 21);
`endif

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
